// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared types and constants for the SD CMD line engines
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        WAIT,
        DLY,
        TX
    } state_t;

    localparam logic [6:0] CRC7_POLY     = 7'h09;
    localparam logic [1:0] RSP_SHORT     = 2'd0;
    localparam logic [1:0] RSP_NOCRC     = 2'd1;
    localparam logic [1:0] RSP_LONG      = 2'd2;
    localparam int         CMD_FRAME_LEN = 48;
    localparam int         RSP_LONG_LEN  = 136;

    // One MSB-first step of x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator, clear has priority over enable
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] r_crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= 7'h00;
        end else if (clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= crc7_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side CMD line engine: command receive, check, response transmit
module sd_cmd_responder
    import sd_cmd_pkg::*;
#(
    parameter int NCR       = 2,
    parameter int NRC_GUARD = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_err,
    input  logic         rsp_valid,
    input  logic         rsp_skip,
    input  logic [1:0]   rsp_type,
    input  logic [127:0] rsp_data,
    output logic         busy
);

    localparam logic [6:0] NCR_LD   = 7'(NCR);
    localparam logic [7:0] GUARD_LD = 8'(NRC_GUARD);

    state_t         r_state;
    state_t         w_next;
    logic [46:0]    r_rx;
    logic [7:0]     r_bit_cnt;
    logic [6:0]     r_dly;
    logic [7:0]     r_guard;
    logic [135:0]   r_tx;
    logic           r_long;
    logic           r_nocrc;
    logic [5:0]     r_cmd_index;
    logic [31:0]    r_cmd_arg;

    logic [6:0]     w_rx_crc;
    logic [6:0]     w_tx_crc;
    logic           w_frame_ok;
    logic           w_tx_bit;
    logic           w_tx_crc_en;
    logic [2:0]     w_crc_idx;
    logic           w_accept;

    sd_crc7 u_rx_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (r_state == IDLE),
        .en      ((r_state == RX) && (r_bit_cnt >= 8'd8)),
        .din     (cmd_in),
        .crc     (w_rx_crc)
    );

    // Long frames exclude the leading start/tx/6'h3F byte from the CRC
    assign w_tx_crc_en = (r_state == TX) && (r_bit_cnt >= 8'd8) &&
                         !(r_long && (r_bit_cnt >= 8'd128));

    sd_crc7 u_tx_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (r_state == DLY),
        .en      (w_tx_crc_en),
        .din     (w_tx_bit),
        .crc     (w_tx_crc)
    );

    assign w_frame_ok = r_rx[46] && r_rx[0] && (w_rx_crc == r_rx[7:1]);
    assign w_accept   = !rsp_skip && rsp_valid;
    assign w_crc_idx  = r_bit_cnt[2:0] - 3'd1;

    always_comb begin
        w_tx_bit = 1'b1;
        if (r_bit_cnt >= 8'd8) begin
            w_tx_bit = r_tx[135];
        end else if (r_bit_cnt != 8'd0) begin
            w_tx_bit = r_nocrc ? 1'b1 : w_tx_crc[w_crc_idx];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!cmd_in && (r_guard == 8'd0)) w_next = RX;
            RX:      if (r_bit_cnt == 8'd0) w_next = CHECK;
            CHECK:   w_next = w_frame_ok ? WAIT : IDLE;
            WAIT: begin
                if (rsp_skip)       w_next = IDLE;
                else if (rsp_valid) w_next = DLY;
            end
            // CHECK already consumed one of the NCR clocks
            DLY:     if (r_dly <= 7'd2) w_next = TX;
            TX:      if (r_bit_cnt == 8'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rx        <= '0;
            r_bit_cnt   <= 8'd0;
            r_dly       <= 7'd0;
            r_guard     <= 8'd0;
            r_tx        <= '0;
            r_long      <= 1'b0;
            r_nocrc     <= 1'b0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && (r_guard != 8'd0)) begin
                r_guard <= r_guard - 8'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_next == RX) begin
                        r_rx      <= '0;
                        r_bit_cnt <= 8'd46;
                    end
                end
                RX: begin
                    r_rx      <= {r_rx[45:0], cmd_in};
                    r_bit_cnt <= (r_bit_cnt != 8'd0) ? r_bit_cnt - 8'd1 : 8'd0;
                end
                CHECK: begin
                    if (w_frame_ok) begin
                        r_cmd_index <= r_rx[45:40];
                        r_cmd_arg   <= r_rx[39:8];
                    end
                end
                WAIT: begin
                    if (w_accept) begin
                        r_dly   <= NCR_LD;
                        r_long  <= (rsp_type == RSP_LONG);
                        r_nocrc <= (rsp_type == RSP_NOCRC);
                        r_tx    <= (rsp_type == RSP_LONG) ?
                                   {2'b00, 6'h3F, rsp_data[127:8], 8'h00} :
                                   {2'b00, rsp_data[37:0], 96'h0};
                    end
                end
                DLY: begin
                    r_dly <= (r_dly != 7'd0) ? r_dly - 7'd1 : 7'd0;
                    if (w_next == TX) begin
                        r_bit_cnt <= r_long ? 8'(RSP_LONG_LEN - 1) : 8'(CMD_FRAME_LEN - 1);
                    end
                end
                TX: begin
                    r_tx      <= {r_tx[134:0], 1'b0};
                    r_bit_cnt <= (r_bit_cnt != 8'd0) ? r_bit_cnt - 8'd1 : 8'd0;
                    if (r_bit_cnt == 8'd0) begin
                        r_guard <= GUARD_LD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_oe    = (r_state == TX);
    assign cmd_out   = (r_state == TX) ? w_tx_bit : 1'b1;
    assign cmd_valid = (r_state == WAIT);
    assign cmd_err   = (r_state == CHECK) && !w_frame_ok;
    assign cmd_index = r_cmd_index;
    assign cmd_arg   = r_cmd_arg;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb/tb_sd_cmd_responder.sv - directed self-checking bench for sd_cmd_responder
module tb_sd_cmd_responder;

    localparam int NCR       = 2;
    localparam int NRC_GUARD = 8;
    localparam logic [127:0] R2_DATA = 128'h0123456789ABCDEFFEDCBA98765432A5;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         cmd_in    = 1'b1;
    logic         rsp_valid = 1'b0;
    logic         rsp_skip  = 1'b0;
    logic [1:0]   rsp_type  = 2'd0;
    logic [127:0] rsp_data  = '0;
    logic         cmd_out, cmd_oe, cmd_valid, cmd_err, busy;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sd_cmd_responder #(.NCR(NCR), .NRC_GUARD(NRC_GUARD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_in    (cmd_in),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .cmd_err   (cmd_err),
        .rsp_valid (rsp_valid),
        .rsp_skip  (rsp_skip),
        .rsp_type  (rsp_type),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    function automatic logic [6:0] crc7_body(input logic [119:0] b);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            fb = b[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Called on a falling edge; returns on the falling edge after the end bit was sampled
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            cmd_in = f[i];
            @(negedge clk);
        end
        cmd_in = 1'b1;
    endtask

    // Called in WAIT with rsp_valid already raised; lat counts falling edges until cmd_oe
    task automatic get_rsp(output logic [135:0] got, output int lat, output int oe_cnt,
                           output logic vld_after);
        got = '0;
        lat = 1;
        @(negedge clk);
        rsp_valid = 1'b0;
        vld_after = cmd_valid;
        while (!cmd_oe && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        oe_cnt = 0;
        while (cmd_oe && oe_cnt < 200) begin
            got = {got[134:0], cmd_out};
            oe_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (cmd_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %0b want 0", cmd_oe); end
        n_cmp++; if (cmd_out !== 1'b1) begin n_fail++; $display("FAIL rst_out: got %0b want 1", cmd_out); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", cmd_valid); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", cmd_err); end
        n_cmp++; if (cmd_index !== 6'd0) begin n_fail++; $display("FAIL rst_index: got %0h want 0", cmd_index); end
        n_cmp++; if (cmd_arg !== 32'd0) begin n_fail++; $display("FAIL rst_arg: got %0h want 0", cmd_arg); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cmd8_r1();
        logic [135:0] got;
        int           lat, oe_cnt;
        logic         vld_after;
        send_frame(48'h48000001AA87);
        n_cmp++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL cmd8_err: got %0b want 0", cmd_err); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cmd8_busy: got %0b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL cmd8_valid: got %0b want 1", cmd_valid); end
        n_cmp++; if (cmd_index !== 6'd8) begin n_fail++; $display("FAIL cmd8_index: got %0d want 8", cmd_index); end
        n_cmp++; if (cmd_arg !== 32'h000001AA) begin n_fail++; $display("FAIL cmd8_arg: got %h want 000001aa", cmd_arg); end
        rsp_type  = 2'd0;
        rsp_data  = {90'h0, 6'd8, 32'h1AA};
        rsp_valid = 1'b1;
        get_rsp(got, lat, oe_cnt, vld_after);
        n_cmp++; if (vld_after !== 1'b0) begin n_fail++; $display("FAIL r1_valid_drop: got %0b want 0", vld_after); end
        n_cmp++; if (lat !== NCR) begin n_fail++; $display("FAIL r1_ncr: got %0d want %0d", lat, NCR); end
        n_cmp++; if (oe_cnt !== 48) begin n_fail++; $display("FAIL r1_len: got %0d want 48", oe_cnt); end
        n_cmp++; if (got[47:0] !== 48'h08000001AA13) begin n_fail++; $display("FAIL r1_frame: got %h want 08000001aa13", got[47:0]); end
        n_cmp++; if (cmd_out !== 1'b1) begin n_fail++; $display("FAIL r1_idle_out: got %0b want 1", cmd_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL r1_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_skip();
        int oe_seen;
        repeat (12) @(negedge clk);
        send_frame(48'h400000000095);
        @(negedge clk);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL cmd0_valid: got %0b want 1", cmd_valid); end
        n_cmp++; if (cmd_index !== 6'd0) begin n_fail++; $display("FAIL cmd0_index: got %0d want 0", cmd_index); end
        n_cmp++; if (cmd_arg !== 32'd0) begin n_fail++; $display("FAIL cmd0_arg: got %h want 0", cmd_arg); end
        rsp_skip  = 1'b1;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_skip  = 1'b0;
        rsp_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL skip_busy: got %0b want 0", busy); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL skip_valid: got %0b want 0", cmd_valid); end
        oe_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (cmd_oe) oe_seen++;
        end
        n_cmp++; if (oe_seen !== 0) begin n_fail++; $display("FAIL skip_oe: got %0d driven clocks want 0", oe_seen); end
    endtask

    task automatic test_bad_crc();
        int err_cnt, vld_seen, oe_seen;
        send_frame(48'h48000001AA89);
        n_cmp++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %0b want 1", cmd_err); end
        err_cnt = 0; vld_seen = 0; oe_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_err)   err_cnt++;
            if (cmd_valid) vld_seen++;
            if (cmd_oe)    oe_seen++;
        end
        n_cmp++; if (err_cnt !== 0) begin n_fail++; $display("FAIL bad_err_pulse: got %0d extra clocks want 0", err_cnt); end
        n_cmp++; if (vld_seen !== 0) begin n_fail++; $display("FAIL bad_valid: got %0d want 0", vld_seen); end
        n_cmp++; if (oe_seen !== 0) begin n_fail++; $display("FAIL bad_oe: got %0d want 0", oe_seen); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy: got %0b want 0", busy); end
        send_frame(48'h48000001AA87);
        n_cmp++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL bad_next_err: got %0b want 0", cmd_err); end
        @(negedge clk);
        n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL bad_next_valid: got %0b want 1", cmd_valid); end
        n_cmp++; if (cmd_arg !== 32'h000001AA) begin n_fail++; $display("FAIL bad_next_arg: got %h want 000001aa", cmd_arg); end
        rsp_skip = 1'b1;
        @(negedge clk);
        rsp_skip = 1'b0;
    endtask

    task automatic test_r3_delayed();
        logic [135:0] got;
        int           lat, oe_cnt;
        logic         vld_after;
        repeat (4) @(negedge clk);
        send_frame(48'h48000001AA87);
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if (cmd_valid !== 1'b1 || cmd_index !== 6'd8) begin
                n_fail++; $display("FAIL wait_hold: got valid %0b index %0d want 1 8", cmd_valid, cmd_index);
            end
        end
        rsp_type  = 2'd1;
        rsp_data  = {90'h0, 6'h3F, 32'h80FF8000};
        rsp_valid = 1'b1;
        get_rsp(got, lat, oe_cnt, vld_after);
        n_cmp++; if (vld_after !== 1'b0) begin n_fail++; $display("FAIL r3_valid_drop: got %0b want 0", vld_after); end
        n_cmp++; if (lat !== NCR) begin n_fail++; $display("FAIL r3_ncr: got %0d want %0d", lat, NCR); end
        n_cmp++; if (oe_cnt !== 48) begin n_fail++; $display("FAIL r3_len: got %0d want 48", oe_cnt); end
        n_cmp++; if (got[47:0] !== 48'h3F80FF8000FF) begin n_fail++; $display("FAIL r3_frame: got %h want 3f80ff8000ff", got[47:0]); end
    endtask

    task automatic test_r2_guard();
        logic [135:0] got, exp;
        int           lat, oe_cnt, busy_seen;
        logic         vld_after;
        repeat (12) @(negedge clk);
        send_frame(48'h48000001AA87);
        @(negedge clk);
        rsp_type  = 2'd2;
        rsp_data  = R2_DATA;
        rsp_valid = 1'b1;
        exp = {2'b00, 6'h3F, R2_DATA[127:8], crc7_body(R2_DATA[127:8]), 1'b1};
        get_rsp(got, lat, oe_cnt, vld_after);
        n_cmp++; if (lat !== NCR) begin n_fail++; $display("FAIL r2_ncr: got %0d want %0d", lat, NCR); end
        n_cmp++; if (oe_cnt !== 136) begin n_fail++; $display("FAIL r2_len: got %0d want 136", oe_cnt); end
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL r2_frame: got %h want %h", got, exp); end
        // Now in guard clock 1; drive a start bit during guard clock 3
        @(negedge clk);
        @(negedge clk);
        cmd_in = 1'b0;
        @(negedge clk);
        cmd_in = 1'b1;
        busy_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy || cmd_err) busy_seen++;
        end
        n_cmp++; if (busy_seen !== 0) begin n_fail++; $display("FAIL guard_ignore: got %0d busy clocks want 0", busy_seen); end
        send_frame(48'h48000001AA87);
        @(negedge clk);
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_index !== 6'd8) begin
            n_fail++; $display("FAIL guard_next: got valid %0b index %0d want 1 8", cmd_valid, cmd_index);
        end
        rsp_skip = 1'b1;
        @(negedge clk);
        rsp_skip = 1'b0;
    endtask

    task automatic test_reset_tx();
        logic [135:0] got;
        int           lat, oe_cnt, guard;
        logic         vld_after;
        repeat (4) @(negedge clk);
        send_frame(48'h48000001AA87);
        @(negedge clk);
        rsp_type  = 2'd0;
        rsp_data  = {90'h0, 6'd8, 32'h1AA};
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        guard = 0;
        while (!cmd_oe && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (cmd_oe !== 1'b1) begin n_fail++; $display("FAIL rtx_pre_oe: got %0b want 1", cmd_oe); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (cmd_oe !== 1'b0) begin n_fail++; $display("FAIL rtx_oe: got %0b want 0", cmd_oe); end
        n_cmp++; if (cmd_out !== 1'b1) begin n_fail++; $display("FAIL rtx_out: got %0b want 1", cmd_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rtx_busy: got %0b want 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame(48'h48000001AA87);
        @(negedge clk);
        n_cmp++; if (cmd_valid !== 1'b1 || cmd_arg !== 32'h1AA) begin
            n_fail++; $display("FAIL rtx_next: got valid %0b arg %h want 1 000001aa", cmd_valid, cmd_arg);
        end
        rsp_valid = 1'b1;
        get_rsp(got, lat, oe_cnt, vld_after);
        n_cmp++; if (oe_cnt !== 48 || got[47:0] !== 48'h08000001AA13) begin
            n_fail++; $display("FAIL rtx_rsp: got len %0d frame %h want 48 08000001aa13", oe_cnt, got[47:0]);
        end
    endtask

    initial begin
        test_reset();
        test_cmd8_r1();
        test_skip();
        test_bad_crc();
        test_r3_delayed();
        test_r2_guard();
        test_reset_tx();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
- Card-side engine for the SD CMD line: the far end of the host CMD controller.
- Deserialises 48-bit host command frames and checks start, transmission and end bits plus CRC7.
- Presents the command index and argument to the card logic, then serialises the requested response (48-bit or 136-bit) after NCR clocks.
- Used by the card emulator and the host-controller verification environment.

Parameters:
- NCR, 2, clocks between the end bit of the command and the response start bit; legal range 2..64.
- NRC_GUARD, 8, clocks after a response end bit during which start bits on cmd_in are ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- cmd_in  input  1  sampled CMD line.
- cmd_out  output  1  CMD drive value.
- cmd_oe  output  1  CMD output enable.
- cmd_valid  output  1  decoded command available; held until accepted.
- cmd_index  output  6  command index (frame bits 45:40).
- cmd_arg  output  32  argument (frame bits 39:8).
- cmd_err  output  1  one-cycle pulse on a CRC or framing error.
- rsp_valid  input  1  response request; accepted when cmd_valid=1.
- rsp_skip  input  1  accept the command with no response (e.g. CMD0).
- rsp_type  input  2  0 = short + CRC7; 1 = short, CRC field 7'h7F (R3); 2 = long R2; 3 = treated as 0.
- rsp_data  input  128  short: [37:0] = frame bits 45:8; long: [127:8] = CID/CSD body, [7:0] ignored.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, cmd_oe=0, cmd_out=1, cmd_valid=0, cmd_err=0, cmd_index=0, cmd_arg=0, guard counter=0.
- IDLE: cmd_in==0 sampled with guard==0 -> RX. CRC7 cleared; start bit counted as bit 47.
- RX:
  - Shift cmd_in MSB-first for 47 more clocks (bits 46..0).
  - CRC7 (x^7+x^3+1) accumulated over bits 47..8.
  - After bit 0 is sampled -> CHECK.
- CHECK (1 clock):
  - Error if bit46!=1, bit0!=1, or computed CRC != bits 7:1.
  - Error -> cmd_err=1 for this clock, then IDLE, no cmd_valid.
  - Ok -> latch cmd_index and cmd_arg, set cmd_valid, go to WAIT.
- WAIT:
  - cmd_valid stays high and is stable.
  - Accept rule: rsp_skip has priority over rsp_valid.
  - rsp_skip -> IDLE.
  - rsp_valid -> latch rsp_type and rsp_data, load delay counter with NCR, go to DLY.
  - cmd_valid drops the clock after accept.
  - cmd_in is ignored in WAIT.
- DLY:
  - cmd_oe=0, counter decrements.
  - First driven bit appears exactly NCR clocks after the command end bit was sampled (WAIT time excluded).
- TX:
  - cmd_oe=1, one bit per clock, MSB-first.
  - Short frame (48 clocks): 0, 0, rsp_data[37:0], CRC7 (or 7'h7F when rsp_type=1), 1. CRC7 covers frame bits 47:8.
  - Long frame (136 clocks): 0, 0, 6'h3F, rsp_data[127:8], CRC7 over the 120 body bits, 1. Start, tx and 6'h3F bits are excluded from the long-frame CRC.
- After the end bit: cmd_oe=0, cmd_out=1, guard counter loaded with NRC_GUARD, -> IDLE. Guard decrements to 0 in IDLE.
- cmd_in is ignored in DLY and TX.
- Counters: bit counter is 8 bits, delay counter is 7 bits. No wrap; each counter saturates at 0.
- A start bit arriving while not in IDLE, or during the guard, is dropped silently.

Decomposition:
- Package sd_cmd_pkg:
  - state enum {IDLE, RX, CHECK, WAIT, DLY, TX}
  - CRC7_POLY=7'h09
  - RSP_SHORT=0, RSP_NOCRC=1, RSP_LONG=2
  - CMD_FRAME_LEN=48, RSP_LONG_LEN=136
- Sub-module sd_crc7: serial CRC7 with clr, en and din inputs and a 7-bit crc output. Two instances: RX check and TX generation. Reusable by the host side.

Test Plan:
- CMD8 frame 0x48000001AA87 -> cmd_valid, cmd_index=8, cmd_arg=0x000001AA, cmd_err=0. Respond rsp_type=0, rsp_data[37:0]={6'd8,32'h1AA} -> after NCR=2 clocks, cmd_out serialises 0x08000001AA13 with cmd_oe=1 for exactly 48 clocks.
- CMD0 frame 0x400000000095 -> cmd_valid, index 0, arg 0. rsp_skip -> cmd_oe never asserts; busy drops the next clock.
- Frame 0x48000001AA89 (bad CRC) -> single cmd_err pulse, no cmd_valid, cmd_oe=0. A following valid CMD8 decodes normally.
- R3: rsp_type=1, rsp_data[37:0]={6'h3F,32'h80FF8000} -> output frame 0x3F80FF8000FF.
- R2: rsp_type=2, arbitrary 120-bit body -> cmd_oe high 136 clocks. Leading bits 00_111111, trailing byte = {CRC7(body),1}. A start bit injected at guard clock 3 is ignored.
- reset_n low at TX bit 20 -> cmd_oe=0 and cmd_out=1 immediately (asynchronous). After release, the next CMD8 is processed correctly.
